// File: rtl/ureg_pkg.sv
// ============================================================================
// Package : ureg_pkg
// Purpose : Shared encodings for the universal shift register command
//           sequencer: command opcodes, register mode codes, FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ureg_pkg;

    // Command opcodes; 101-111 all behave as NOP, OP_NOP is the canonical one.
    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_NOP  = 3'b101;

    // Register mode select (REG_CTRL) encodings.
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHUP = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;
    localparam logic [1:0] MODE_SHDN = 2'b11;

    // Sequencer FSM state.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_FIN   = 2'd3;

    // True for the four opcodes that step the register.
    function automatic logic op_is_shift(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
    endfunction

    // Collapse the reserved opcodes onto OP_NOP so downstream decode sees one code.
    function automatic logic [2:0] op_normalize(input logic [2:0] op);
        return (op > OP_ROR) ? OP_NOP : op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ureg_step_counter.sv
// ============================================================================
// Module  : ureg_step_counter
// Purpose : CNT_W-bit down-counter holding the remaining shift steps.
// Ports   : CLOCK, RESET      - clock, synchronous active-high reset
//           load, load_value  - load a new step count (has priority)
//           dec               - decrement by one (saturates at zero)
//           count, zero       - current count and count==0 flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ureg_step_counter #(
    parameter int CNT_W = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/ureg_shift_sequencer.sv
// ============================================================================
// Module  : ureg_shift_sequencer
// Purpose : Command sequencer driving an 8-bit universal shift register.
//           Accepts LOAD / logical shift / rotate commands over a valid-ready
//           handshake and steps the register one cycle at a time.
// Ports   : CLOCK, RESET           - clock, synchronous active-high reset
//           CMD_VALID/READY        - command handshake (READY only in IDLE)
//           CMD_OP, CMD_CNT,
//           CMD_DATA               - opcode, step count, load value
//           SER_IN                 - fill bit for logical shifts
//           STALL                  - freezes an active shift
//           Q_IN                   - register Q feedback
//           REG_CTRL, REG_SIN,
//           REG_D, REG_EN          - register mode / serial / parallel / enable
//           SER_OUT, SER_VLD       - bit leaving the register and its strobe
//           BUSY, DONE             - activity flag, completion pulse
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ureg_shift_sequencer
    import ureg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD_OP,
    input  logic [CNT_W-1:0] CMD_CNT,
    input  logic [WIDTH-1:0] CMD_DATA,
    input  logic             SER_IN,
    input  logic             STALL,
    input  logic [WIDTH-1:0] Q_IN,
    output logic [1:0]       REG_CTRL,
    output logic             REG_SIN,
    output logic [WIDTH-1:0] REG_D,
    output logic             REG_EN,
    output logic             SER_OUT,
    output logic             SER_VLD,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             accept;
    logic             shift_step;

    // Only the end bits of Q feed back; the middle bits are intentionally unused.
    logic unused_q_mid;
    assign unused_q_mid = ^Q_IN[WIDTH-2:1];

    assign accept     = (state == ST_IDLE) && CMD_VALID;
    // The zero guard keeps a stray empty count from ever enabling the register.
    assign shift_step = (state == ST_SHIFT) && !STALL && !cnt_zero;

    ureg_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .load       (accept),
        .load_value (CMD_CNT),
        .dec        (shift_step),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    // ------------------------------------------------------------------
    // State, opcode and load data
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= ST_IDLE;
            op    <= OP_NOP;
            data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        op   <= op_normalize(CMD_OP);
                        data <= CMD_DATA;
                        if (CMD_OP == OP_LOAD) begin
                            state <= ST_LOAD;
                        end else if (op_is_shift(CMD_OP) && (CMD_CNT != '0)) begin
                            state <= ST_SHIFT;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_LOAD: begin
                    state <= ST_FIN;
                end
                ST_SHIFT: begin
                    // Leave once the step that empties the counter has been issued.
                    if (cnt_zero) begin
                        state <= ST_FIN;
                    end else if (shift_step && (cnt == CNT_ONE)) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register drive decode from registered state / op
    // ------------------------------------------------------------------
    always_comb begin
        REG_CTRL = MODE_HOLD;
        REG_EN   = 1'b0;
        REG_D    = '0;
        REG_SIN  = 1'b0;
        SER_OUT  = 1'b0;
        SER_VLD  = 1'b0;
        case (state)
            ST_LOAD: begin
                REG_CTRL = MODE_LOAD;
                REG_EN   = 1'b1;
                REG_D    = data;
            end
            ST_SHIFT: begin
                if (shift_step) begin
                    REG_EN  = 1'b1;
                    SER_VLD = 1'b1;
                    case (op)
                        OP_SHL: begin
                            REG_CTRL = MODE_SHUP;
                            REG_SIN  = SER_IN;
                            SER_OUT  = Q_IN[WIDTH-1];
                        end
                        OP_SHR: begin
                            REG_CTRL = MODE_SHDN;
                            REG_SIN  = SER_IN;
                            SER_OUT  = Q_IN[0];
                        end
                        OP_ROL: begin
                            REG_CTRL = MODE_SHUP;
                            REG_SIN  = Q_IN[WIDTH-1];
                            SER_OUT  = Q_IN[WIDTH-1];
                        end
                        OP_ROR: begin
                            REG_CTRL = MODE_SHDN;
                            REG_SIN  = Q_IN[0];
                            SER_OUT  = Q_IN[0];
                        end
                        default: begin
                            REG_EN  = 1'b0;
                            SER_VLD = 1'b0;
                        end
                    endcase
                end
            end
            default: begin
            end
        endcase
    end

    assign CMD_READY = (state == ST_IDLE);
    assign BUSY      = (state != ST_IDLE);
    assign DONE      = (state == ST_FIN);

endmodule

`default_nettype wire

// File: tb/tb_ureg_shift_sequencer.sv
// ============================================================================
// Module  : tb_ureg_shift_sequencer
// Purpose : Self-checking bench for ureg_shift_sequencer. A behavioural
//           register sits on the DUT's register port; a work-list model
//           predicts every cycle's outputs and the resulting register value.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ureg_shift_sequencer;

    logic       CLOCK;
    logic       RESET;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [2:0] CMD_OP;
    logic [3:0] CMD_CNT;
    logic [7:0] CMD_DATA;
    logic       SER_IN;
    logic       STALL;
    logic [7:0] Q_IN;
    logic [1:0] REG_CTRL;
    logic       REG_SIN;
    logic [7:0] REG_D;
    logic       REG_EN;
    logic       SER_OUT;
    logic       SER_VLD;
    logic       BUSY;
    logic       DONE;

    ureg_shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_CNT   (CMD_CNT),
        .CMD_DATA  (CMD_DATA),
        .SER_IN    (SER_IN),
        .STALL     (STALL),
        .Q_IN      (Q_IN),
        .REG_CTRL  (REG_CTRL),
        .REG_SIN   (REG_SIN),
        .REG_D     (REG_D),
        .REG_EN    (REG_EN),
        .SER_OUT   (SER_OUT),
        .SER_VLD   (SER_VLD),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // Universal shift register the sequencer drives.
    logic [7:0] q = 8'h00;
    assign Q_IN = q;
    always @(posedge CLOCK) begin
        if (REG_EN) begin
            case (REG_CTRL)
                2'b01:   q <= {q[6:0], REG_SIN};
                2'b10:   q <= REG_D;
                2'b11:   q <= {REG_SIN, q[7:1]};
                default: q <= q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Checker state (written only by the compare process)
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    typedef enum int {K_LOAD, K_SHIFT, K_FIN} kind_e;
    kind_e      work[$];
    logic [7:0] m_q = 8'h00;
    logic [2:0] m_op = 3'd5;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_start = 8'h00;
    int         m_n = 0;
    int         lat_run = 0, en_run = 0, stl_run = 0;
    int         last_lat = 0, last_en = 0, last_stl = 0;
    int         pin_seen = 0;
    logic       after_rst = 1'b0;

    // Pins requested by the stimulus process (written only by it); -1 skips.
    int pin_seq = 0;
    int pin_q = -1, pin_lat = -1, pin_en = -1, pin_stl = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        int s = n % 8;
        return 8'(((int'(v) << s) | (int'(v) >> (8 - s))) & 255);
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] v, input int n);
        int s = n % 8;
        return 8'(((int'(v) >> s) | (int'(v) << (8 - s))) & 255);
    endfunction

    // ------------------------------------------------------------------
    // Compare process: one pass per cycle, sampled on the falling edge
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge CLOCK);
            begin
                bit         idle_now;
                bit         left, rot;
                logic       out_b, sin_b;
                idle_now = (work.size() == 0);

                if (pin_seq != pin_seen) begin
                    pin_seen = pin_seq;
                    if (pin_q   >= 0) chk("pin_q",   32'(Q_IN),     32'(pin_q));
                    if (pin_lat >= 0) chk("pin_lat", 32'(last_lat), 32'(pin_lat));
                    if (pin_en  >= 0) chk("pin_en",  32'(last_en),  32'(pin_en));
                    if (pin_stl >= 0) chk("pin_stl", 32'(last_stl), 32'(pin_stl));
                end

                if (after_rst) chk("reset_sin", 32'(REG_SIN), 32'd0);

                if (idle_now) begin
                    chk("idle_ready", 32'(CMD_READY), 32'd1);
                    chk("idle_busy",  32'(BUSY),      32'd0);
                    chk("idle_done",  32'(DONE),      32'd0);
                    chk("idle_en",    32'(REG_EN),    32'd0);
                    chk("idle_ctrl",  32'(REG_CTRL),  32'd0);
                    chk("idle_d",     32'(REG_D),     32'd0);
                    chk("idle_vld",   32'(SER_VLD),   32'd0);
                end else begin
                    lat_run++;
                    chk("busy_ready", 32'(CMD_READY), 32'd0);
                    chk("busy_busy",  32'(BUSY),      32'd1);
                    case (work[0])
                        K_LOAD: begin
                            chk("load_ctrl", 32'(REG_CTRL), 32'd2);
                            chk("load_en",   32'(REG_EN),   32'd1);
                            chk("load_d",    32'(REG_D),    32'(m_data));
                            chk("load_vld",  32'(SER_VLD),  32'd0);
                            chk("load_done", 32'(DONE),     32'd0);
                            m_q = m_data;
                            void'(work.pop_front());
                        end
                        K_SHIFT: begin
                            chk("shift_done", 32'(DONE),  32'd0);
                            chk("shift_d",    32'(REG_D), 32'd0);
                            if (STALL) begin
                                stl_run++;
                                chk("stall_en",   32'(REG_EN),   32'd0);
                                chk("stall_ctrl", 32'(REG_CTRL), 32'd0);
                                chk("stall_vld",  32'(SER_VLD),  32'd0);
                            end else begin
                                en_run++;
                                left  = (m_op == 3'd1) || (m_op == 3'd3);
                                rot   = (m_op == 3'd3) || (m_op == 3'd4);
                                out_b = left ? m_q[7] : m_q[0];
                                sin_b = rot ? out_b : SER_IN;
                                chk("shift_q",    32'(Q_IN),     32'(m_q));
                                chk("shift_en",   32'(REG_EN),   32'd1);
                                chk("shift_ctrl", 32'(REG_CTRL), left ? 32'd1 : 32'd3);
                                chk("shift_vld",  32'(SER_VLD),  32'd1);
                                chk("shift_sin",  32'(REG_SIN),  32'(sin_b));
                                chk("shift_out",  32'(SER_OUT),  32'(out_b));
                                if (left) m_q = 8'(((int'(m_q) << 1) | int'(sin_b)) & 255);
                                else      m_q = 8'((int'(m_q) >> 1) | (int'(sin_b) << 7));
                                void'(work.pop_front());
                            end
                        end
                        default: begin
                            chk("fin_done", 32'(DONE),     32'd1);
                            chk("fin_en",   32'(REG_EN),   32'd0);
                            chk("fin_ctrl", 32'(REG_CTRL), 32'd0);
                            chk("fin_d",    32'(REG_D),    32'd0);
                            chk("fin_vld",  32'(SER_VLD),  32'd0);
                            chk("fin_q",    32'(Q_IN),     32'(m_q));
                            if (m_op == 3'd3 && m_n > 0) chk("fin_rol", 32'(Q_IN), 32'(rotl(m_start, m_n)));
                            if (m_op == 3'd4 && m_n > 0) chk("fin_ror", 32'(Q_IN), 32'(rotr(m_start, m_n)));
                            last_lat = lat_run;
                            last_en  = en_run;
                            last_stl = stl_run;
                            void'(work.pop_front());
                        end
                    endcase
                end

                if (RESET) begin
                    work.delete();
                end else if (idle_now && CMD_VALID) begin
                    m_op    = CMD_OP;
                    m_data  = CMD_DATA;
                    m_n     = int'(CMD_CNT);
                    m_start = Q_IN;
                    lat_run = 0;
                    en_run  = 0;
                    stl_run = 0;
                    if (CMD_OP == 3'd0) begin
                        work.push_back(K_LOAD);
                    end else if (CMD_OP >= 3'd1 && CMD_OP <= 3'd4) begin
                        for (int i = 0; i < m_n; i++) work.push_back(K_SHIFT);
                    end
                    work.push_back(K_FIN);
                end
                after_rst = RESET;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int          stall_mode = 0;   // 0 never, 1 scripted, 2 random
    int          ser_mode   = 0;   // 0 zero, 1 one, 2 random
    logic [15:0] stall_script = 16'h0000;
    int          scr_idx = 0;

    task automatic tick();
        @(posedge CLOCK);
        #1;
        case (stall_mode)
            0: STALL = 1'b0;
            1: begin
                STALL = (scr_idx < 16) ? stall_script[scr_idx] : 1'b0;
                scr_idx++;
            end
            default: STALL = ($urandom_range(3) == 0);
        endcase
        case (ser_mode)
            0:       SER_IN = 1'b0;
            1:       SER_IN = 1'b1;
            default: SER_IN = 1'($urandom_range(1));
        endcase
    endtask

    // Holds CMD_VALID until the sequencer takes the command.
    task automatic issue(input logic [2:0] op, input logic [3:0] n, input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_CNT   = n;
        CMD_DATA  = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge CLOCK);
            acc = CMD_READY;
            if (acc) scr_idx = 0;
            tick();
        end
        CMD_VALID = 1'b0;
        if (!acc) begin
            $display("FAIL issue_timeout: CMD_READY actual 0 required 1");
            $fatal(1, "command never accepted");
        end
    endtask

    task automatic wait_done(input int bound);
        bit d;
        d = 1'b0;
        for (int i = 0; i < bound && !d; i++) begin
            @(negedge CLOCK);
            d = DONE;
            tick();
        end
        if (!d) begin
            $display("FAIL done_timeout: DONE actual 0 required 1");
            $fatal(1, "DONE never seen");
        end
    endtask

    task automatic pin(input int pq, input int pl, input int pe, input int ps);
        pin_q   = pq;
        pin_lat = pl;
        pin_en  = pe;
        pin_stl = ps;
        pin_seq++;
        tick();
    endtask

    initial begin
        RESET     = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP    = 3'd5;
        CMD_CNT   = 4'd0;
        CMD_DATA  = 8'h00;
        SER_IN    = 1'b0;
        STALL     = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
        tick();

        // LOAD: DONE in the second cycle after the accepting cycle.
        issue(3'd0, 4'd0, 8'hA5); wait_done(10); pin(8'hA5, 2, 0, 0);

        // ROL 3 of 0x81: 03, 06, 0C.
        issue(3'd0, 4'd0, 8'h81); wait_done(10);
        issue(3'd3, 4'd3, 8'h00); wait_done(20); pin(8'h0C, 4, 3, 0);

        // SHR 4 of 0xF0 with zero fill.
        issue(3'd0, 4'd0, 8'hF0); wait_done(10);
        issue(3'd2, 4'd4, 8'h00); wait_done(20); pin(8'h0F, 5, 4, 0);

        // SHL 5 of 0x03 with one fill, second and third shift cycles stalled:
        // 5 steps + 2 stalls, DONE in the following cycle.
        issue(3'd0, 4'd0, 8'h03); wait_done(10);
        ser_mode = 1; stall_mode = 1; stall_script = 16'h0006;
        issue(3'd1, 4'd5, 8'h00); wait_done(30); pin(8'h7F, 8, 5, 2);
        ser_mode = 0; stall_mode = 0;

        // Zero-count rotate and NOP complete immediately without touching Q.
        issue(3'd3, 4'd0, 8'h00); wait_done(10); pin(8'h7F, 1, 0, 0);
        issue(3'd7, 4'd5, 8'h55); wait_done(10); pin(8'h7F, 1, 0, 0);

        // Rotate count beyond the width wraps: ROL 10 of 0x81 = ROL 2 = 0x06.
        issue(3'd0, 4'd0, 8'h81); wait_done(10);
        issue(3'd3, 4'd10, 8'h00); wait_done(30); pin(8'h06, 11, 10, 0);

        // Second command presented while busy waits for IDLE.
        issue(3'd3, 4'd3, 8'h00);
        issue(3'd2, 4'd1, 8'h00); wait_done(20); pin(-1, 2, 1, 0);

        // Reset in the second cycle of ROR 6 of 0x01 leaves Q after two steps.
        issue(3'd0, 4'd0, 8'h01); wait_done(10);
        issue(3'd4, 4'd6, 8'h00);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        pin(8'h40, -1, -1, -1);

        // Randomized traffic with stalls, random fill and occasional reset.
        stall_mode = 2;
        ser_mode   = 2;
        for (int k = 0; k < 300; k++) begin
            issue(3'($urandom_range(7)), 4'($urandom_range(15)), 8'($urandom_range(255)));
            if ($urandom_range(29) == 0) begin
                repeat ($urandom_range(3)) tick();
                RESET = 1'b1;
                tick();
                RESET = 1'b0;
            end else begin
                repeat ($urandom_range(6)) tick();
            end
        end
        stall_mode = 0;
        repeat (60) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
